// File: rtl/instr_prefetch.sv
// Instruction-byte prefetch queue: fetches sequential program bytes into a DEPTH-entry FIFO for CPU decode.
// Head byte is visible one cycle after its mem_ready; fetching stalls when the queue is full and resumes on pop.
module instr_prefetch #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [7:0]  mem_data,
  input  logic        mem_ready,
  output logic        ins_valid,
  output logic [7:0]  ins_byte,
  output logic [15:0] ins_pc,
  input  logic        ins_pop,
  input  logic        flush,
  input  logic [15:0] flush_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      fetch_pc_q;

  logic [7:0]  byte_mem [DEPTH];
  logic [15:0] pc_mem   [DEPTH];

  logic full, empty, push, pop_ok;

  assign full   = (count_q == CNT_FULL);
  assign empty  = (count_q == '0);
  assign pop_ok = ins_pop && !empty && !flush;
  // A full queue may still accept a byte when the head leaves on the same edge.
  assign push   = mem_rd_en && mem_ready && !flush && (!full || pop_ok);

  assign mem_rd_en = (state_q == FETCH);
  assign mem_addr  = fetch_pc_q;

  assign ins_valid = !empty;
  assign ins_byte  = byte_mem[head_q];
  assign ins_pc    = pc_mem[head_q];

  always_comb begin
    count_d = count_q;
    state_d = state_q;
    if (flush) begin
      count_d = '0;
      state_d = FETCH;
    end else begin
      case ({push, pop_ok})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      case (state_q)
        IDLE:    if (count_d < CNT_FULL) state_d = FETCH;
        FETCH:   if (push && (count_d == CNT_FULL)) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      fetch_pc_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (flush) begin
        head_q     <= tail_q;
        fetch_pc_q <= flush_pc;
      end else begin
        if (push) begin
          tail_q     <= tail_q + PTR_ONE;
          fetch_pc_q <= fetch_pc_q + 16'h0001;
        end
        if (pop_ok) head_q <= head_q + PTR_ONE;
      end
    end
  end

  // Payload storage needs no reset: ins_valid gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      byte_mem[tail_q] <= mem_data;
      pc_mem[tail_q]   <= fetch_pc_q;
    end
  end

endmodule

// File: doc/instr_prefetch.md
INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port mem_addr, output, 16, program-memory byte address (registered).
REQ-005 SHALL have port mem_rd_en, output, 1, fetch request to program memory (registered).
REQ-006 SHALL have port mem_data, input, 8, program byte, valid when mem_ready=1.
REQ-007 SHALL have port mem_ready, input, 1, memory completes the current request this cycle.
REQ-008 SHALL have port ins_valid, output, 1, head byte available to CPU decode.
REQ-009 SHALL have port ins_byte, output, 8, head byte of queue.
REQ-010 SHALL have port ins_pc, output, 16, address the head byte was fetched from.
REQ-011 SHALL have port ins_pop, input, 1, CPU consumes head byte this cycle.
REQ-012 SHALL have port flush, input, 1, discard queue and redirect fetch (jump/call/ret/interrupt).
REQ-013 SHALL have port flush_pc, input, 16, new fetch address, sampled when flush=1.

Function
REQ-014 SHALL hold a circular FIFO of DEPTH entries, each {byte[7:0], pc[15:0]}, plus count (0..DEPTH) and fetch_pc[15:0].
REQ-015 SHALL implement states IDLE (mem_rd_en=0) and FETCH (mem_rd_en=1, mem_addr=fetch_pc).
REQ-016 SHALL move IDLE->FETCH when the count after this edge is < DEPTH; move FETCH->IDLE when a completing fetch leaves the count at DEPTH; otherwise stay.
REQ-017 SHALL, on an edge with mem_rd_en=1 and mem_ready=1 (no flush): write {mem_data, fetch_pc} at tail, fetch_pc+1.
REQ-018 SHALL keep mem_rd_en and mem_addr stable while mem_ready=0 (wait states of any length).
REQ-019 SHALL sustain one byte per cycle when mem_ready=1 and CPU pops every cycle (back-to-back, mem_rd_en never drops).
REQ-020 SHALL drive ins_valid = (count != 0), with ins_byte/ins_pc from the head entry combinationally from registers.
REQ-021 SHALL, on ins_pop=1 with count != 0, advance head; ins_pop with count = 0 SHALL be ignored.
REQ-022 SHALL leave count unchanged on simultaneous push and pop; push is allowed when full if a pop occurs on the same edge.
REQ-023 SHALL wrap fetch_pc from 0xFFFF to 0x0000; head/tail pointers wrap modulo DEPTH.
REQ-024 SHALL give flush priority over push and pop: on flush edge count=0, head=tail, fetch_pc=flush_pc, state=FETCH, mem_addr=flush_pc.
REQ-025 SHALL discard mem_data completing on the flush edge; the in-flight request is abandoned (memory tolerates abort).
REQ-026 SHALL deassert ins_valid in the cycle after flush; first post-flush byte valid one cycle after its mem_ready.
REQ-027 SHALL never present a byte whose pc differs from its fetch address; ins_pc increments by 1 between consecutive bytes absent flush.

Reset
REQ-028 SHALL, while reset=0, force count=0, head=tail=0, fetch_pc=0x0000, state=IDLE, mem_rd_en=0, mem_addr=0x0000, ins_valid=0.
REQ-029 SHALL enter FETCH on the first rising edge after reset deasserts (mem_rd_en=1, mem_addr=0x0000).
REQ-030 SHALL return to REQ-028 values immediately on reset assertion mid-fetch, discarding queue contents.

Verification
REQ-031 Reset release, mem_ready=1, memory returns 0x0A everywhere, no pops -> addresses 0x0000..0x0003 fetched on consecutive cycles, then mem_rd_en=0 with count=4, ins_byte=0x0A, ins_pc=0x0000.
REQ-032 Full queue, ins_pop held high, mem_ready=1 -> one byte per cycle, ins_pc 0x0000,0x0001,... contiguous, mem_rd_en continuously 1.
REQ-033 mem_ready low 3 cycles on address 0x0005 -> mem_addr held at 0x0005, mem_rd_en=1, no push until mem_ready=1.
REQ-034 flush with flush_pc=0x1234 while mem_ready=1 and queue holds 3 bytes -> next cycle ins_valid=0, mem_addr=0x1234; first valid byte shows ins_pc=0x1234.
REQ-035 flush_pc=0xFFFE, no pops -> ins_pc sequence 0xFFFE,0xFFFF,0x0000,0x0001.
REQ-036 reset asserted mid-fetch with count=2 -> mem_rd_en=0, ins_valid=0 immediately; after release fetch restarts at 0x0000.
